// File: rtl/nw_fill_dir_writer.sv
// Needleman-Wunsch matrix-fill stage: scores each cell of the (N+1)x(N+1) grid in raster order,
// writes one direction symbol per cell and reports H(N,N).
module nw_fill_dir_writer #(
  parameter int        N        = 128,
  parameter int        BitAddr  = $clog2(N + 1),
  parameter int        SW       = 16,
  parameter int        CW       = 2,
  parameter int signed MATCH    = 1,
  parameter int signed MISMATCH = -1,
  parameter int signed GAP      = -2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [BitAddr:0]     a_addr,
  output logic [BitAddr:0]     b_addr,
  input  logic [CW-1:0]        a_char,
  input  logic [CW-1:0]        b_char,
  output logic                 dir_we,
  output logic [BitAddr:0]     dir_i,
  output logic [BitAddr:0]     dir_j,
  output logic [2:0]           dir_symbol,
  output logic signed [SW-1:0] final_score,
  output logic [1:0]           dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE; dir_we is a one-cycle
  // write strobe with no backpressure, qualifying dir_i/dir_j/dir_symbol in the same cycle.

  localparam int AW = BitAddr + 1;
  localparam logic [AW-1:0] LAST = AW'(N);
  localparam logic signed [SW-1:0] MATCH_S    = SW'(MATCH);
  localparam logic signed [SW-1:0] MISMATCH_S = SW'(MISMATCH);
  localparam logic signed [SW-1:0] GAP_S      = SW'(GAP);
  localparam logic [2:0] SYM_NONE = 3'b000;
  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FILL, S_DONE} state_t;

  // state names what dir_* currently presents; (pi,pj) is the cell being scored this cycle.
  state_t                state, state_n;
  logic                  run, run_n;
  logic [AW-1:0]         pi, pj, pi_n, pj_n;
  logic [AW-1:0]         a_addr_n, b_addr_n, di_n, dj_n;
  logic                  we_n, proc, last_cell;
  logic [2:0]            sym_n, sym_val;
  logic signed [SW-1:0]  fin_n;
  logic signed [SW-1:0]  rowbuf [0:N];
  logic signed [SW-1:0]  diag_r, left_r, up_old;
  logic signed [SW-1:0]  s_val, d_val, u_val, l_val, h_val;
  logic [BitAddr-1:0]    rb_idx;

  assign rb_idx    = pj[BitAddr-1:0];
  assign busy      = (state == S_INIT) || (state == S_FILL);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    up_old  = rowbuf[rb_idx];
    s_val   = (a_char == b_char) ? MATCH_S : MISMATCH_S;
    d_val   = diag_r + s_val;
    u_val   = up_old + GAP_S;
    l_val   = left_r + GAP_S;
    h_val   = '0;
    sym_val = SYM_NONE;
    if (pi == '0) begin
      if (pj != '0) begin
        h_val   = l_val;
        sym_val = SYM_LEFT;
      end
    end else if (pj == '0) begin
      h_val   = u_val;
      sym_val = SYM_UP;
    end else if ((d_val >= u_val) && (d_val >= l_val)) begin
      h_val   = d_val;
      sym_val = SYM_DIAG;
    end else if (u_val >= l_val) begin
      h_val   = u_val;
      sym_val = SYM_UP;
    end else begin
      h_val   = l_val;
      sym_val = SYM_LEFT;
    end
  end

  always_comb begin
    state_n   = state;
    run_n     = run;
    pi_n      = pi;
    pj_n      = pj;
    a_addr_n  = a_addr;
    b_addr_n  = b_addr;
    we_n      = 1'b0;
    di_n      = dir_i;
    dj_n      = dir_j;
    sym_n     = dir_symbol;
    fin_n     = final_score;
    proc      = 1'b0;
    last_cell = (pi == LAST) && (pj == LAST);
    unique case (state)
      S_IDLE: begin
        if (start) begin
          proc  = 1'b1;
          run_n = 1'b1;
        end
      end
      S_INIT, S_FILL: begin
        if (run) proc = 1'b1;
        else     state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (proc) begin
      we_n    = 1'b1;
      di_n    = pi;
      dj_n    = pj;
      sym_n   = sym_val;
      state_n = (pi == '0) ? S_INIT : S_FILL;
      if (last_cell) begin
        pi_n  = '0;
        pj_n  = '0;
        run_n = 1'b0;
        fin_n = h_val;
      end else if (pj == LAST) begin
        pi_n = pi + AW'(1);
        pj_n = '0;
      end else begin
        pj_n = pj + AW'(1);
      end
      // Characters for the cell after next are requested now, so sync-read data lines up.
      if (pj_n != LAST) begin
        a_addr_n = pi_n;
        b_addr_n = pj_n + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      run         <= 1'b0;
      pi          <= '0;
      pj          <= '0;
      a_addr      <= '0;
      b_addr      <= '0;
      dir_we      <= 1'b0;
      dir_i       <= '0;
      dir_j       <= '0;
      dir_symbol  <= SYM_NONE;
      final_score <= '0;
      diag_r      <= '0;
      left_r      <= '0;
    end else begin
      state       <= state_n;
      run         <= run_n;
      pi          <= pi_n;
      pj          <= pj_n;
      a_addr      <= a_addr_n;
      b_addr      <= b_addr_n;
      dir_we      <= we_n;
      dir_i       <= di_n;
      dir_j       <= dj_n;
      dir_symbol  <= sym_n;
      final_score <= fin_n;
      if (proc) begin
        diag_r <= up_old;
        left_r <= h_val;
      end
    end
  end

  // Row buffer holds the previous row's H values; its contents are irrelevant after a reset.
  always_ff @(posedge clk) begin
    if (proc) rowbuf[rb_idx] <= h_val;
  end

endmodule

// File: tb/tb_nw_fill_dir_writer.sv
// Directed bench for nw_fill_dir_writer: table of N=4 fills with hand-computed direction
// matrices, plus sequences for start-while-busy, reset mid-fill and an N=1 tie case.
module tb_nw_fill_dir_writer;

  localparam int N4  = 4;
  localparam int AW4 = $clog2(N4 + 1) + 1;
  localparam int N1  = 1;
  localparam int AW1 = $clog2(N1 + 1) + 1;
  localparam int SW  = 16;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_C = 2'd1;

  logic clk, rst;

  logic                 start4, busy4, done4, we4;
  logic [AW4-1:0]       a_addr4, b_addr4, i4, j4;
  logic [1:0]           a_char4, b_char4, st4;
  logic [2:0]           sym4;
  logic signed [SW-1:0] score4;
  logic [1:0]           mem_a4 [0:(1<<AW4)-1];
  logic [1:0]           mem_b4 [0:(1<<AW4)-1];

  logic                 start1, busy1, done1, we1;
  logic [AW1-1:0]       a_addr1, b_addr1, i1, j1;
  logic [1:0]           a_char1, b_char1, st1;
  logic [2:0]           sym1;
  logic signed [SW-1:0] score1;
  logic [1:0]           mem_a1 [0:(1<<AW1)-1];
  logic [1:0]           mem_b1 [0:(1<<AW1)-1];

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [7:0] a;     // position k (1..4) in bits [2k-1:2k-2]
    logic [7:0] b;
    string      syms;  // 25 symbols row-major: 0=none D=diag U=up L=left
    int         fin;
    int         poke;  // pulse start mid-fill and during done
  } vec_t;

  vec_t vecs [2];

  nw_fill_dir_writer #(.N(N4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .a_addr(a_addr4), .b_addr(b_addr4), .a_char(a_char4), .b_char(b_char4),
    .dir_we(we4), .dir_i(i4), .dir_j(j4), .dir_symbol(sym4),
    .final_score(score4), .dbg_state(st4)
  );

  nw_fill_dir_writer #(.N(N1), .MISMATCH(-2), .GAP(-1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_addr(a_addr1), .b_addr(b_addr1), .a_char(a_char1), .b_char(b_char1),
    .dir_we(we1), .dir_i(i1), .dir_j(j1), .dir_symbol(sym1),
    .final_score(score1), .dbg_state(st1)
  );

  // clock / reset / sequence memories
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_char4 <= mem_a4[a_addr4];
    b_char4 <= mem_b4[b_addr4];
    a_char1 <= mem_a1[a_addr1];
    b_char1 <= mem_b1[b_addr1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sym_of(input byte c);
    case (c)
      "D":     return 1;
      "U":     return 2;
      "L":     return 4;
      default: return 0;
    endcase
  endfunction

  task automatic load4(input int v);
    logic [7:0] av, bv;
    av = vecs[v].a;
    bv = vecs[v].b;
    for (int k = 0; k < (1 << AW4); k++) begin
      mem_a4[k] = 2'd0;
      mem_b4[k] = 2'd0;
    end
    for (int k = 1; k <= N4; k++) begin
      mem_a4[k] = av[2*k-2 +: 2];
      mem_b4[k] = bv[2*k-2 +: 2];
    end
  endtask

  // driver + monitor for one N=4 fill
  task automatic run4(input int v);
    int cyc, nw, first_we, last_we, done_cyc, busy_first, busy_at_done, quiet;
    int ei, ej, es;
    load4(v);
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    cyc = 0; nw = 0; first_we = -1; last_we = -1; done_cyc = -1; busy_at_done = -1;
    busy_first = int'(busy4);
    while (done_cyc < 0 && cyc < 100) begin
      if (we4) begin
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        if (nw < 25) begin
          ei = nw / 5;
          ej = nw % 5;
          es = sym_of(vecs[v].syms[nw]);
          check($sformatf("%s_cell_%0d_%0d(i*100+j*10+sym)", vecs[v].name, ei, ej),
                int'(i4) * 100 + int'(j4) * 10 + int'(sym4), ei * 100 + ej * 10 + es);
        end
        nw++;
      end
      if (done4) begin
        done_cyc = cyc;
        busy_at_done = int'(busy4);
      end
      start4 = (vecs[v].poke != 0) && (cyc == 10 || done4);
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
    check({vecs[v].name, "_done_seen"}, int'(done_cyc >= 0), 1);
    check({vecs[v].name, "_busy_after_start"}, busy_first, 1);
    check({vecs[v].name, "_first_write_cycle"}, first_we, 0);
    check({vecs[v].name, "_write_count"}, nw, 25);
    check({vecs[v].name, "_contiguous_span"}, last_we - first_we, 24);
    check({vecs[v].name, "_done_latency"}, done_cyc - last_we, 1);
    check({vecs[v].name, "_busy_at_done"}, busy_at_done, 0);
    check({vecs[v].name, "_final_score"}, int'(score4), vecs[v].fin);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      if (we4 || busy4 || done4) quiet++;
      @(negedge clk);
    end
    check({vecs[v].name, "_idle_after_done"}, quiet, 0);
    check({vecs[v].name, "_final_score_held"}, int'(score4), vecs[v].fin);
  endtask

  initial begin
    int cyc, found, quiet, nw, last_we, done_cyc;
    vecs[0] = '{"acgt_acgt", 8'he4, 8'he4, "0LLLLUDLLLUUDLLUUUDLUUUUD", 4, 0};
    vecs[1] = '{"aaaa_cccc", 8'h00, 8'h55, "0LLLLUDDDDUDDDDUDDDDUDDDD", -4, 1};

    rst = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    for (int k = 0; k < (1 << AW1); k++) begin
      mem_a1[k] = 2'd0;
      mem_b1[k] = 2'd0;
    end
    load4(0);
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy4), 0);
    check("reset_done", int'(done4), 0);
    check("reset_dir_we", int'(we4), 0);
    check("reset_dir_ij", int'(i4) * 100 + int'(j4), 0);
    check("reset_dir_symbol", int'(sym4), 0);
    check("reset_addr", int'(a_addr4) * 100 + int'(b_addr4), 0);
    check("reset_final_score", int'(score4), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 2; v++) run4(v);

    // reset asserted mid row 2 aborts at once
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    found = 0;
    cyc = 0;
    while (!found && cyc < 100) begin
      if (we4 && i4 == AW4'(2) && j4 == AW4'(1)) found = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rst_mid_row2_reached", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_dir_we", int'(we4), 0);
    check("rst_mid_busy", int'(busy4), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (we4 || busy4 || done4) quiet++;
    end
    check("rst_mid_quiet_after", quiet, 0);
    run4(0);

    // N=1 tie: d=u=l=-2 resolves to DIAG
    mem_a1[1] = CH_A;
    mem_b1[1] = CH_C;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cyc = 0; nw = 0; last_we = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < 50) begin
      if (we1) begin
        if (nw < 4)
          check($sformatf("tie_cell_%0d_%0d(i*100+j*10+sym)", nw / 2, nw % 2),
                int'(i1) * 100 + int'(j1) * 10 + int'(sym1),
                (nw / 2) * 100 + (nw % 2) * 10 + sym_of(byte'("0LUD" >> (8 * (3 - nw)))));
        nw++;
        last_we = cyc;
      end
      if (done1) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    check("tie_write_count", nw, 4);
    check("tie_done_latency", done_cyc - last_we, 1);
    check("tie_final_score", int'(score1), -2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
